// File: rtl/ddr3_cmd_responder.sv
// DDR3 device-side responder: decodes bus commands, tracks open rows per bank and
// loops write bursts back as read bursts. Optional tRCD checking: DDR3_TRCD_CHECK_EN.
module ddr3_cmd_responder #(
  parameter int DQ_W  = 16,
  parameter int ROW_B = 1,
  parameter int CL    = 6,
  parameter int CWL   = 5,
  parameter int TRCD  = 5
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            ddr3_reset_n,
  input  logic            ddr3_cke,
  input  logic            ddr3_cs_n,
  input  logic            ddr3_ras_n,
  input  logic            ddr3_cas_n,
  input  logic            ddr3_we_n,
  input  logic [2:0]      ddr3_ba,
  input  logic [13:0]     ddr3_addr,
  input  logic            ddr3_dm,
  input  logic [DQ_W-1:0] dq_in,
  output logic [DQ_W-1:0] dq_out,
  output logic            dq_oe,
  output logic            dqs_out,
  output logic [7:0]      ref_cnt,
  output logic [3:0]      err_flags
);
  localparam int IDX_W  = 3 + ROW_B + 7 + 3;
  localparam int BASE_W = IDX_W - 3;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_WAIT, S_WR_BURST, S_RD_WAIT, S_RD_BURST
  } state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [BASE_W-1:0]  r_base;
  logic [DQ_W-1:0]    r_mem [0:(1<<IDX_W)-1];
  logic [DQ_W-1:0]    r_rd_data;
  logic               r_dq_oe;
  logic               r_dqs;
  logic [7:0]         r_ref_cnt;
  logic [3:0]         r_err;

  logic [7:0]         w_open;
  logic [ROW_B-1:0]   w_row [8];
  logic [2:0]         w_cmd;
  logic               w_cmd_en, w_act, w_pre, w_ref, w_rd, w_wr;
  logic               w_idle, w_bank_open, w_go;
  logic               w_closed_err, w_act_err, w_busy_err, w_trcd_viol;
  logic [IDX_W-1:0]   w_idx;
  logic               w_unused_addr;

  assign w_cmd_en = ddr3_cke & ~ddr3_cs_n & ddr3_reset_n;
  assign w_cmd    = {ddr3_ras_n, ddr3_cas_n, ddr3_we_n};
  assign w_act    = w_cmd_en && (w_cmd == 3'b011);
  assign w_wr     = w_cmd_en && (w_cmd == 3'b100);
  assign w_rd     = w_cmd_en && (w_cmd == 3'b101);
  assign w_pre    = w_cmd_en && (w_cmd == 3'b010);
  assign w_ref    = w_cmd_en && (w_cmd == 3'b001);

  assign w_idle       = (r_state == S_IDLE);
  assign w_bank_open  = w_open[ddr3_ba];
  assign w_go         = (w_rd | w_wr) & w_idle & w_bank_open;
  assign w_busy_err   = (w_rd | w_wr) & ~w_idle;
  assign w_closed_err = (w_rd | w_wr) & w_idle & ~w_bank_open;
  assign w_act_err    = w_act & w_bank_open;
  assign w_idx        = {r_base, r_cnt[2:0]};
  // Only the row LSBs, A10 and the column bits [9:3] carry meaning here.
  assign w_unused_addr = ^ddr3_addr;

`ifdef DDR3_TRCD_CHECK_EN
  localparam int TC_W = $clog2(TRCD + 1);
  logic [7:0] w_trcd_busy;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bank
      logic             r_open_q;
      logic [ROW_B-1:0] r_row_q;

      always_ff @(posedge clk_in) begin
        if (!rst_n || !ddr3_reset_n) begin
          r_open_q <= 1'b0;
        end else if (w_act && ddr3_ba == 3'(gi)) begin
          r_open_q <= 1'b1;
        end else if (w_pre && (ddr3_addr[10] || ddr3_ba == 3'(gi))) begin
          r_open_q <= 1'b0;
        end
      end

      always_ff @(posedge clk_in) begin
        if (w_act && ddr3_ba == 3'(gi)) r_row_q <= ddr3_addr[ROW_B-1:0];
      end

      assign w_open[gi] = r_open_q;
      assign w_row[gi]  = r_row_q;

`ifdef DDR3_TRCD_CHECK_EN
      // Counts down from TRCD-1 after ACT; non-zero means the bank is still too young.
      logic [TC_W-1:0] r_trcd_q;
      always_ff @(posedge clk_in) begin
        if (!rst_n) begin
          r_trcd_q <= '0;
        end else if (w_act && ddr3_ba == 3'(gi)) begin
          r_trcd_q <= TC_W'(TRCD - 1);
        end else if (r_trcd_q != '0) begin
          r_trcd_q <= r_trcd_q - TC_W'(1);
        end
      end
      assign w_trcd_busy[gi] = (r_trcd_q != '0);
`endif
    end
  endgenerate

`ifdef DDR3_TRCD_CHECK_EN
  assign w_trcd_viol = w_go & w_trcd_busy[ddr3_ba];
`else
  logic [7:0] w_unused_trcd;
  assign w_unused_trcd = 8'(TRCD);
  assign w_trcd_viol   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_next = w_wr ? S_WR_WAIT : S_RD_WAIT;
          w_cnt_next   = w_wr ? CNT_W'(CWL - 2) : CNT_W'(CL - 2);
        end
      end
      S_WR_WAIT, S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = (r_state == S_WR_WAIT) ? S_WR_BURST : S_RD_BURST;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_WR_BURST, S_RD_BURST: begin
        if (r_cnt == CNT_W'(7)) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
    if (!ddr3_reset_n) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_base    <= '0;
      r_dq_oe   <= 1'b0;
      r_dqs     <= 1'b0;
      r_ref_cnt <= '0;
      r_err     <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // The burst keeps this index even if its bank is re-activated mid-burst.
      if (w_go) r_base <= {ddr3_ba, w_row[ddr3_ba], ddr3_addr[9:3]};
      r_dq_oe <= ddr3_reset_n && (r_state == S_RD_BURST);
      r_dqs   <= ddr3_reset_n && (r_state == S_RD_BURST) && !r_cnt[0];
      if (w_ref && r_ref_cnt != 8'hFF) r_ref_cnt <= r_ref_cnt + 8'd1;
      r_err <= r_err | {w_trcd_viol, w_busy_err, w_act_err, w_closed_err};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_n && ddr3_reset_n && r_state == S_WR_BURST && !ddr3_dm) r_mem[w_idx] <= dq_in;
  end

  always_ff @(posedge clk_in) begin
    if (r_state == S_RD_BURST) r_rd_data <= r_mem[w_idx];
  end

  assign dq_out    = r_dq_oe ? r_rd_data : '0;
  assign dq_oe     = r_dq_oe;
  assign dqs_out   = r_dqs;
  assign ref_cnt   = r_ref_cnt;
  assign err_flags = r_err;
endmodule
